heading_integrator: RTL and testbench
=====================================

Name: heading_integrator

Overview:
Sequential, parametrised successor to the combinational differential-drive heading calculator. On each accepted odometry sample it computes delta_theta = (distance_right - distance_left) * 1000 / WHEEL_BASE_MM in milliradians using a multi-cycle restoring divider instead of a combinational divide. It accumulates the result into a wrapped absolute heading. It sits between the wheel-encoder distance counters and the pose/navigation logic, using a valid/ready handshake.

Parameters:
DATA_W, 32, signed width of the distance inputs and of delta_theta / heading outputs (16..32)
WHEEL_BASE_MM, 100, wheel separation in mm (integer, >0; 0 is illegal and unchecked)
PI_MRAD, 3142, pi in milliradians; heading range is (-PI_MRAD, +PI_MRAD]

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
in_valid  in  1  distance sample valid
in_ready  out  1  block can accept a sample (high only in IDLE)
distance_right  in  DATA_W  signed right-wheel distance since last sample, mm
distance_left  in  DATA_W  signed left-wheel distance since last sample, mm
clear_heading  in  1  synchronous zeroing of the heading accumulator
out_valid  out  1  one-cycle pulse: delta_theta/heading updated
delta_theta  out  DATA_W  signed delta theta, mrad, saturated to DATA_W
heading  out  DATA_W  signed accumulated heading, mrad, wrapped

Behaviour:
- Reset (reset_n low, async): state=IDLE, in_ready=1, out_valid=0, delta_theta=0, heading=0, divider regs cleared. Reset mid-operation aborts the sample with no output.
- NUM_W = DATA_W+11. The difference needs DATA_W+1 bits; the ×1000 needs 10 more.
- IDLE: in_ready=1. On in_valid&in_ready at edge E0:
  - latch diff = sign-extended right - left
  - form num = diff*1000 (NUM_W bits)
  - store sign and |num|
  - go to DIVIDE
- DIVIDE: restoring unsigned division of |num| by WHEEL_BASE_MM, one quotient bit per cycle, MSB first, NUM_W cycles (edges E1..E_NUM_W). in_ready=0. in_valid is ignored.
- ACCUM (edge E_NUM_W+1):
  - Apply sign to the quotient, giving truncation toward zero (matches Verilog signed /). The remainder is discarded.
  - q = signed quotient.
  - delta_theta <= q saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - dc = q clamped to [-PI_MRAD, +PI_MRAD]. The clamp is for accumulation only.
  - s = heading + dc (DATA_W+1 bits).
  - If s > PI_MRAD, heading <= s - 2*PI_MRAD. If s <= -PI_MRAD, heading <= s + 2*PI_MRAD. Otherwise heading <= s.
  - out_valid <= 1 for exactly one cycle; state returns to IDLE.
- Latency: out_valid is high in the cycle after edge E_NUM_W+1, i.e. NUM_W+1 cycles after acceptance (44 for DATA_W=32). The next sample can be accepted in that same out_valid cycle.
- Zero difference gives delta_theta=0 and an unchanged heading, but still pulses out_valid.
- clear_heading is honoured in any state; heading <= 0 at the next edge.
  - If it coincides with the ACCUM edge, the clear wins: heading=0, while delta_theta and out_valid still update.
  - clear_heading does not abort a division.
- delta_theta and heading hold their values between updates.
- No back-pressure on the output: out_valid is a pulse, and the consumer must sample it.

Test Plan:
- Reset, then right=150, left=100 -> out_valid 44 cycles after acceptance, delta_theta=500, heading=500; in_ready low throughout DIVIDE.
- From heading=0: right=100, left=137 -> delta_theta=-370 (-37000/100, truncation toward zero), heading=-370. Then right=1, left=0 -> delta_theta=10, heading=-360.
- Wrap: drive heading to 3000 (samples summing to 3000), then diff=50 -> delta_theta=500, s=3500 -> heading=-2784. Negative mirror: heading=-3000, diff=-50 -> heading=2784.
- Saturation/clamp:
  - right=10000, left=0 from heading=0 -> delta_theta=100000, heading=3142 (clamped; exactly +PI stays).
  - right=2147483647, left=-2147483648 -> delta_theta=2147483647, heading wraps consistently.
- Control:
  - clear_heading asserted on the ACCUM edge -> heading=0 and out_valid pulses with a valid delta_theta.
  - in_valid held high continuously -> exactly one acceptance per NUM_W+2 cycles.
  - reset_n pulsed low mid-DIVIDE -> all outputs 0, no out_valid.

Source files
------------

// File: rtl/heading_integrator.sv
// heading_integrator
//   Differential-drive heading integrator. Each accepted odometry sample
//   yields delta_theta = (distance_right - distance_left) * 1000 / WHEEL_BASE_MM
//   in milliradians. A restoring divider produces one quotient bit per cycle.
//   The clamped result is accumulated into a heading wrapped to
//   (-PI_MRAD, +PI_MRAD].
//
// Ports
//   clock          in   rising-edge system clock
//   reset_n        in   asynchronous active-low reset
//   in_valid       in   distance sample valid
//   in_ready       out  sample can be accepted (IDLE only)
//   distance_right in   signed right-wheel distance since last sample, mm
//   distance_left  in   signed left-wheel distance since last sample, mm
//   clear_heading  in   synchronous zeroing of the heading accumulator
//   out_valid      out  one-cycle pulse: delta_theta/heading updated
//   delta_theta    out  signed delta theta, mrad, saturated to DATA_W
//   heading        out  signed accumulated heading, mrad, wrapped
module heading_integrator #(
    parameter int DATA_W        = 32,
    parameter int WHEEL_BASE_MM = 100,
    parameter int PI_MRAD       = 3142
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] distance_right,
    input  logic signed [DATA_W-1:0] distance_left,
    input  logic                     clear_heading,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] delta_theta,
    output logic signed [DATA_W-1:0] heading
);

    // diff needs DATA_W+1 bits; the x1000 scaling needs 10 more
    localparam int NUM_W = DATA_W + 11;
    localparam int CNT_W = $clog2(NUM_W);

    localparam logic signed [NUM_W-1:0] K1000 = NUM_W'(1000);
    localparam logic        [NUM_W:0]   DVSR  = (NUM_W+1)'(WHEEL_BASE_MM);

    localparam logic signed [NUM_W:0] Q_MAX =
        {{(NUM_W+2-DATA_W){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [NUM_W:0] Q_MIN =
        {{(NUM_W+2-DATA_W){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [NUM_W:0]  Q_PI  = (NUM_W+1)'(PI_MRAD);
    localparam logic signed [DATA_W:0] S_PI  = (DATA_W+1)'(PI_MRAD);
    localparam logic signed [DATA_W:0] S_2PI = (DATA_W+1)'(2 * PI_MRAD);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ACCUM
    } state_t;

    state_t state, state_nx;

    logic [CNT_W-1:0] bit_cnt;
    // work holds the dividend magnitude; the quotient shifts in from the
    // LSB as dividend bits leave at the MSB
    logic [NUM_W-1:0] work;
    logic [NUM_W-1:0] rem;
    logic             neg;

    logic signed [DATA_W:0]   diff;
    logic signed [NUM_W-1:0]  diff_ext;
    logic signed [NUM_W-1:0]  num;
    logic        [NUM_W-1:0]  num_abs;
    logic        [NUM_W:0]    trial;
    logic                     q_bit;
    logic signed [NUM_W:0]    q;
    logic signed [DATA_W-1:0] sat_q;
    logic signed [DATA_W:0]   dc;
    logic signed [DATA_W:0]   s;
    logic signed [DATA_W-1:0] heading_nx;

    // sample scaling and magnitude
    always_comb begin
        diff     = {distance_right[DATA_W-1], distance_right}
                 - {distance_left[DATA_W-1], distance_left};
        diff_ext = {{10{diff[DATA_W]}}, diff};
        num      = diff_ext * K1000;
        num_abs  = num[NUM_W-1] ? -num : num;
    end

    // one restoring-division step
    always_comb begin
        trial = {rem, work[NUM_W-1]};
        q_bit = (trial >= DVSR);
    end

    // signed quotient, saturation, clamp and wrap
    always_comb begin
        q = neg ? -$signed({1'b0, work}) : $signed({1'b0, work});

        if (q > Q_MAX)
            sat_q = DATA_W'(Q_MAX);
        else if (q < Q_MIN)
            sat_q = DATA_W'(Q_MIN);
        else
            sat_q = DATA_W'(q);

        if (q > Q_PI)
            dc = S_PI;
        else if (q < -Q_PI)
            dc = -S_PI;
        else
            dc = (DATA_W+1)'(q);

        s = {heading[DATA_W-1], heading} + dc;

        if (s > S_PI)
            heading_nx = DATA_W'(s - S_2PI);
        else if (s <= -S_PI)
            heading_nx = DATA_W'(s + S_2PI);
        else
            heading_nx = DATA_W'(s);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nx = DIVIDE;
            end
            DIVIDE: begin
                if (bit_cnt == CNT_W'(NUM_W - 1))
                    state_nx = ACCUM;
            end
            ACCUM:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt     <= '0;
            work        <= '0;
            rem         <= '0;
            neg         <= 1'b0;
            out_valid   <= 1'b0;
            delta_theta <= '0;
            heading     <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        neg     <= num[NUM_W-1];
                        work    <= num_abs;
                        rem     <= '0;
                        bit_cnt <= '0;
                    end
                end
                DIVIDE: begin
                    work    <= {work[NUM_W-2:0], q_bit};
                    rem     <= q_bit ? NUM_W'(trial - DVSR) : trial[NUM_W-1:0];
                    bit_cnt <= bit_cnt + 1'b1;
                end
                ACCUM: begin
                    delta_theta <= sat_q;
                    heading     <= heading_nx;
                    out_valid   <= 1'b1;
                end
                default: ;
            endcase
            // clear overrides an accumulation landing on the same edge
            if (clear_heading)
                heading <= '0;
        end
    end

endmodule

// File: tb/tb_heading_integrator.sv
module tb_heading_integrator;

    localparam int DATA_W = 32;
    localparam int WB     = 100;
    localparam int PI     = 3142;

    logic                     clock = 1'b0;
    logic                     reset_n = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     clear_heading = 1'b0;
    logic signed [DATA_W-1:0] distance_right = '0;
    logic signed [DATA_W-1:0] distance_left = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [DATA_W-1:0] delta_theta;
    logic signed [DATA_W-1:0] heading;

    heading_integrator #(
        .DATA_W(DATA_W),
        .WHEEL_BASE_MM(WB),
        .PI_MRAD(PI)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .distance_right(distance_right),
        .distance_left(distance_left),
        .clear_heading(clear_heading),
        .out_valid(out_valid),
        .delta_theta(delta_theta),
        .heading(heading)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic signed [31:0] d;
        logic signed [31:0] h;
    } exp_t;

    exp_t   sb[$];
    exp_t   mon_e;
    int     total = 0;
    int     bad = 0;
    longint hmodel = 0;
    int     acc_cyc[3];
    int     k;
    int     cyc;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // reference model: native truncating divide, saturate, clamp, wrap
    task automatic expect_sample(input longint r, input longint l, input bit clr);
        longint q, d, dc, s;
        exp_t   e;
        q = ((r - l) * 1000) / WB;
        if (q > 64'sd2147483647) d = 64'sd2147483647;
        else if (q < -64'sd2147483648) d = -64'sd2147483648;
        else d = q;
        if (q > PI) dc = PI;
        else if (q < -PI) dc = -PI;
        else dc = q;
        s = hmodel + dc;
        if (s > PI) s = s - 2 * PI;
        else if (s <= -PI) s = s + 2 * PI;
        hmodel = clr ? 0 : s;
        e.d = d[31:0];
        e.h = hmodel[31:0];
        sb.push_back(e);
    endtask

    always @(negedge clock) begin
        if (reset_n && out_valid) begin
            check("out_expected", (sb.size() > 0) ? 1 : 0, 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("delta_theta", delta_theta, mon_e.d);
                check("heading", heading, mon_e.h);
            end
        end
    end

    task automatic send(input longint r, input longint l, input bit clr_on_accum,
                        input string tag);
        int n;
        bit rdy_low;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clock); #1; n++;
        end
        check({tag, "_ready_before"}, in_ready, 1);
        distance_right = r[31:0];
        distance_left  = l[31:0];
        in_valid = 1'b1;
        expect_sample(r, l, clr_on_accum);
        @(posedge clock); #1;
        in_valid = 1'b0;
        n = 0;
        rdy_low = 1'b1;
        while (!out_valid && n < 100) begin
            if (in_ready) rdy_low = 1'b0;
            @(posedge clock); #1; n++;
            if (clr_on_accum && n == 43) clear_heading = 1'b1;
            if (n == 44) clear_heading = 1'b0;
        end
        check({tag, "_latency"}, n, 44);
        check({tag, "_busy_ready_low"}, rdy_low, 1);
        check({tag, "_ready_at_out"}, in_ready, 1);
    endtask

    task automatic clear_acc(input string tag);
        clear_heading = 1'b1;
        @(posedge clock); #1;
        clear_heading = 1'b0;
        hmodel = 0;
        check(tag, heading, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(posedge clock);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_delta", delta_theta, 0);
        check("rst_heading", heading, 0);
        reset_n = 1'b1;
        @(posedge clock); #1;

        send(150, 100, 1'b0, "basic");
        send(7, 7, 1'b0, "zero_diff");

        clear_acc("clear1");
        send(100, 137, 1'b0, "neg_trunc");
        send(1, 0, 1'b0, "small_pos");

        clear_acc("clear2");
        send(300, 0, 1'b0, "to_3000");
        send(50, 0, 1'b0, "wrap_pos");

        clear_acc("clear3");
        send(0, 300, 1'b0, "to_m3000");
        send(0, 50, 1'b0, "wrap_neg");

        clear_acc("clear4");
        send(10000, 0, 1'b0, "clamp_pi");
        send(64'sd2147483647, -64'sd2147483648, 1'b0, "saturate");

        send(150, 100, 1'b1, "clear_on_accum");

        // in_valid held high: acceptances every NUM_W+2 cycles
        distance_right = 3;
        distance_left  = 2;
        in_valid = 1'b1;
        k = 0;
        cyc = 0;
        while (k < 3 && cyc < 300) begin
            if (in_ready) begin
                acc_cyc[k] = cyc;
                k++;
                expect_sample(3, 2, 1'b0);
            end
            @(posedge clock); #1; cyc++;
        end
        in_valid = 1'b0;
        check("cont_accepts", k, 3);
        check("cont_gap1", acc_cyc[1] - acc_cyc[0], 45);
        check("cont_gap2", acc_cyc[2] - acc_cyc[1], 45);
        repeat (50) @(posedge clock);
        #1;
        check("cont_heading", heading, 30);

        // reset in the middle of a division aborts it silently
        distance_right = 150;
        distance_left  = 100;
        in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (20) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_delta", delta_theta, 0);
        check("midrst_heading", heading, 0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        hmodel = 0;
        repeat (60) @(posedge clock);
        #1;
        check("midrst_no_output", sb.size(), 0);
        check("midrst_heading_after", heading, 0);
        check("midrst_ready_after", in_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
